// File: rtl/mips_pkg.sv
// Shared state encoding and stream constants for the instruction-memory loader.
// Latency: none (declarations only).
// Backpressure: n/a.
package mips_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        CSUM   = 3'd5,
        DONE   = 3'd6,
        ERR    = 3'd7
    } state_t;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    // States in which the loader pulls bytes from upstream.
    function automatic logic accepts_bytes(state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CSUM);
    endfunction

    // States that belong to an in-progress load.
    function automatic logic load_active(state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == WRITE) || (s == CSUM);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs bytes big-endian into a 32-bit word (first byte lands in [31:24]).
// Latency: word updates the cycle after each shift; word_full is combinational on the 4th shift.
// Backpressure: none of its own; the caller gates shift_en with the transfer handshake.
module byte_packer
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        shift_en,
    input  logic        clr,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        word_full
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0] cnt;

    assign word_full = shift_en && (cnt == LAST_BYTE);

    // Shift incoming bytes in from the bottom and count them; clr only restarts the count
    // so the completed word stays visible while it is being written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            word <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (shift_en) begin
            cnt  <= cnt + 2'd1;
            word <= {word[23:0], din};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> 32-bit instruction-memory writes, then releases the CPU.
// Latency: each word is written the cycle after its 4th byte transfers; optional macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR byte.
// Backpressure: byte_ready is a registered function of state only; it drops during WRITE, IDLE, DONE and ERR.
module imem_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Largest legal word count; compared against the full 16-bit length.
    localparam logic [16:0] CAP = 17'(1) << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t END_ST = CSUM;
`else
    localparam state_t END_ST = DONE;
`endif

    state_t      state;
    state_t      nxt;
    logic        xfer;
    logic        start_ok;
    logic        pk_shift;
    logic        pk_clr;
    logic        pk_full;
    logic [31:0] pk_word;
    logic [7:0]  n_hi;
    logic [15:0] n_len;
    logic [ADDR_W:0] wcnt;
    logic [16:0] len_rx;
    logic [16:0] words_next;

    assign xfer       = byte_valid && byte_ready;
    assign start_ok   = start && ((state == IDLE) || (state == DONE) || (state == ERR));
    assign len_rx     = {1'b0, n_hi, byte_data};
    assign words_next = 17'(wcnt) + 17'd1;
    assign pk_shift   = xfer && (state == DATA);
    assign pk_clr     = start_ok || (state == WRITE);

    assign im_addr  = wcnt[ADDR_W-1:0];
    assign im_wdata = pk_word;

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (pk_shift),
        .clr       (pk_clr),
        .din       (byte_data),
        .word      (pk_word),
        .word_full (pk_full)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    // Running XOR over data bytes only; length bytes never enter it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum <= '0;
        end else if (start_ok) begin
            csum <= '0;
        end else if (pk_shift) begin
            csum <= csum ^ byte_data;
        end
    end
`endif

    // Next-state decode.
    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) nxt = LEN_HI;
            end
            LEN_HI: begin
                if (xfer) nxt = LEN_LO;
            end
            LEN_LO: begin
                if (xfer) begin
                    if (len_rx > CAP)          nxt = ERR;
                    else if (len_rx == 17'd0)  nxt = END_ST;
                    else                       nxt = DATA;
                end
            end
            DATA: begin
                if (pk_full) nxt = WRITE;
            end
            WRITE: begin
                if (words_next < {1'b0, n_len}) nxt = DATA;
                else                            nxt = END_ST;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (xfer) nxt = (byte_data == csum) ? DONE : ERR;
            end
`endif
            default: nxt = IDLE;
        endcase
    end

    // State register with outputs registered from the next state so they track it exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            byte_ready <= 1'b0;
            im_we      <= 1'b0;
            busy       <= 1'b0;
            cpu_run    <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= nxt;
            byte_ready <= accepts_bytes(nxt);
            im_we      <= (nxt == WRITE);
            busy       <= load_active(nxt);
            cpu_run    <= (nxt == DONE);
            done       <= (nxt == DONE);
            err        <= (nxt == ERR);
        end
    end

    // Length capture and word index; the index advances once per WRITE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_hi  <= '0;
            n_len <= '0;
            wcnt  <= '0;
        end else if (start_ok) begin
            n_hi  <= '0;
            n_len <= '0;
            wcnt  <= '0;
        end else begin
            if (xfer && (state == LEN_HI)) n_hi  <= byte_data;
            if (xfer && (state == LEN_LO)) n_len <= {n_hi, byte_data};
            if (state == WRITE)            wcnt  <= words_next[ADDR_W:0];
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader upstream of the single-cycle CPU's 4 KB instruction memory.
- Receives a byte stream over a valid/ready handshake and packs the bytes big-endian into 32-bit words.
- Writes each word into instruction memory at consecutive word addresses from 0.
- Holds the CPU out of execution until the image is fully written, then releases it.

Parameters:
- ADDR_W, 10, instruction-memory word-address width. Capacity is 2^ADDR_W words; 1024 words = 4 KB.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- byte_valid  in  1  upstream byte present.
- byte_data  in  8  upstream byte.
- byte_ready  out  1  loader accepts a byte this cycle. A transfer occurs when byte_valid && byte_ready.
- im_we  out  1  instruction-memory write strobe, one cycle per word.
- im_addr  out  ADDR_W  word address for the write.
- im_wdata  out  32  word to write.
- cpu_run  out  1  1 = CPU may execute (drives the CPU reset release); 0 = CPU held in reset.
- busy  out  1  load in progress.
- done  out  1  last load completed successfully; sticky until the next start.
- err  out  1  last load failed; sticky until the next start.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; word counter, byte counter and packing register cleared.
- Stream format: 2-byte word count N (big-endian), then 4*N data bytes. Within each word the first byte is bits [31:24].
- States and transitions:
  - IDLE -> LEN_HI on start.
  - LEN_HI -> LEN_LO after 1 transfer; that byte is N[15:8].
  - LEN_LO -> DATA after 1 transfer; that byte is N[7:0].
  - LEN_LO -> DONE instead of DATA when N == 0.
  - LEN_LO -> ERR instead of DATA when N > 2^ADDR_W. The length check uses the full 16-bit N, never a truncated value.
  - DATA -> WRITE when the 4th byte of a word transfers.
  - WRITE -> DATA when words written < N; otherwise WRITE -> DONE.
  - DONE / ERR -> LEN_HI on start.
- WRITE lasts exactly one cycle:
  - im_we = 1, im_addr = word index, im_wdata = packed word; the byte counter resets.
  - im_we is 0 in every other state.
- byte_ready:
  - 1 in LEN_HI, LEN_LO and DATA.
  - 0 in IDLE, WRITE, DONE and ERR.
  - It is driven by state only and has no combinational path from byte_valid.
- Latency: the im_we cycle is the cycle immediately after the 4th byte's transfer.
- Word index: starts at 0 and increments after each WRITE. It never wraps, because N <= 2^ADDR_W is enforced at LEN_LO.
- Status outputs:
  - busy = 1 in LEN_HI, LEN_LO, DATA and WRITE.
  - cpu_run = 1 only in DONE.
  - done = 1 only in DONE; err = 1 only in ERR.
- Boundary conditions:
  - start while busy is ignored.
  - A start pulse in the same cycle as a byte transfer in DONE/ERR: start wins, and the byte is not consumed because byte_ready = 0.
  - byte_valid low for any number of cycles stalls the loader with no timeout.
  - rst asserted mid-load returns the loader to IDLE with cpu_run = 0. Memory contents already written are left as is.
  - Re-load from DONE drops cpu_run to 0 in the cycle after start.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - One extra trailing byte follows the data. It equals the XOR of all 4*N data bytes; the length bytes are excluded.
  - Added state CSUM is entered after the last WRITE, or directly from LEN_LO when N == 0, with byte_ready = 1.
  - On transfer: CSUM -> DONE if the byte matches the running XOR, otherwise CSUM -> ERR.
  - The running XOR is cleared on start.
- Undefined: no CSUM state and no running-XOR register; the stream ends after the data bytes.

Decomposition:
- Shared package (mips_pkg):
  - state encoding constants IDLE, LEN_HI, LEN_LO, DATA, WRITE, CSUM, DONE, ERR (3 bits);
  - LEN_BYTES = 2;
  - BYTES_PER_WORD = 4.
- Sub-module byte_packer:
  - 2-bit byte counter plus a 32-bit shift register;
  - inputs shift_en and clr; outputs word and word_full.
  - The loader FSM instantiates it once.

Test Plan:
- Load N=2, bytes 00 02 | 24 08 00 05 | 24 09 00 0A -> im_we pulses writing addr 0 = 0x24080005 and addr 1 = 0x2409000A; then done=1, cpu_run=1, err=0.
- Same stream with byte_valid deasserted 3 cycles between every byte -> identical writes and no extra im_we pulses; byte_ready=0 during each WRITE cycle.
- Length bytes 04 01 (N=1025) with ADDR_W=10 -> ERR, err=1, cpu_run=0, no im_we pulse. Length 04 00 then 4096 bytes -> last write at addr 0x3FF, then done=1.
- Length 00 00 -> DONE two transfers after start with no write; with IMEM_LOADER_CHECKSUM_EN, a trailing byte 00 is required first.
- rst pulsed low after the 6th byte of an N=2 load -> all outputs 0 immediately. A new start and a full stream -> correct writes from addr 0.
- With IMEM_LOADER_CHECKSUM_EN, data 11 22 33 44:
  - checksum byte 44 -> done=1;
  - checksum byte 45 -> err=1, cpu_run=0.
